ycbcr_to_rgb565: RTL and testbench

Pipelined colour-space converter from 8-bit YCbCr (BT.601 full-range, JPEG-style) back to RGB888 and RGB565. It sits after the luma/chroma processing stages, such as the Sobel path and overlays, and feeds the RGB565 display/LCD interface. Pixel data and the h_sync/v_sync/data_en timing signals are delayed together so they leave the block aligned. Throughput is one pixel per clk, with no back-pressure.

---
 rtl/ycbcr_to_rgb565_pkg.sv | 12 +
 rtl/ycbcr_to_rgb565_if.sv | 24 ++
 rtl/ycbcr_to_rgb565_clamp.sv | 17 +
 rtl/ycbcr_to_rgb565.sv | 76 +++++++
 tb/tb_ycbcr_to_rgb565.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/ycbcr_to_rgb565_pkg.sv
// Shared constants for the YCbCr -> RGB converter.
// The coefficients are BT.601 full-range values scaled by 2^FRAC_BITS.
package ycc_pkg;
   localparam logic signed [17:0] KR_CR     = 18'sd359;
   localparam logic signed [17:0] KG_CB     = 18'sd88;
   localparam logic signed [17:0] KG_CR     = 18'sd183;
   localparam logic signed [17:0] KB_CB     = 18'sd454;
   localparam logic signed [8:0]  C_OFFSET  = 9'sd128;
   localparam int                 FRAC_BITS = 8;
   // Also used by the rgb_to_ycbcr side to keep its timing signals aligned.
   localparam int                 PIPE_LAT  = 4;
endpackage

// File: rtl/ycbcr_to_rgb565_if.sv
// Pixel bus for the converter: the YCbCr input with its timing, and the RGB output with its timing.
interface ycbcr_to_rgb565_if;
   logic [7:0]  i_y;
   logic [7:0]  i_cb;
   logic [7:0]  i_cr;
   logic        i_h_sync;
   logic        i_v_sync;
   logic        i_data_en;
   logic [23:0] o_rgb888;
   logic [15:0] o_rgb565;
   logic        o_h_sync;
   logic        o_v_sync;
   logic        o_data_en;

   modport master (
      output i_y, i_cb, i_cr, i_h_sync, i_v_sync, i_data_en,
      input  o_rgb888, o_rgb565, o_h_sync, o_v_sync, o_data_en
   );

   modport slave (
      input  i_y, i_cb, i_cr, i_h_sync, i_v_sync, i_data_en,
      output o_rgb888, o_rgb565, o_h_sync, o_v_sync, o_data_en
   );
endinterface

// File: rtl/ycbcr_to_rgb565_clamp.sv
// Saturates a signed 8.8 fixed-point channel sum to an unsigned 8-bit value.
module ycc_clamp_u8 (
   input  logic signed [17:0] sum,
   output logic [7:0]         value
);
   logic unused_frac;

   assign unused_frac = ^sum[7:0];

   always_comb begin
      value = sum[15:8];
      if (sum[17])
         value = 8'h00;
      else if (sum[16])
         value = 8'hff;
   end
endmodule

// File: rtl/ycbcr_to_rgb565.sv
// Four-stage YCbCr -> RGB888/RGB565 converter. The timing signals travel in a shift register
// of the same depth as the datapath, so they leave the block aligned with the pixel data.
module ycbcr_to_rgb565
   import ycc_pkg::*;
#(
   parameter bit ROUND      = 1'b1,
   parameter bit BLANK_ZERO = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   ycbcr_to_rgb565_if.slave pix
);
   localparam logic signed [17:0] RND = ROUND ? 18'sd128 : 18'sd0;

   logic signed [8:0]  cb_s1, cr_s1;
   logic signed [17:0] y_s1, y_s2;
   logic signed [17:0] p_r_cr, p_g_cb, p_g_cr, p_b_cb;
   logic signed [17:0] r_sum, g_sum, b_sum;
   logic [7:0]         r_sat, g_sat, b_sat;
   logic [23:0]        rgb;
   logic [PIPE_LAT-1:0] hs_d, vs_d, de_d;

   ycc_clamp_u8 u_clamp_r (.sum(r_sum), .value(r_sat));
   ycc_clamp_u8 u_clamp_g (.sum(g_sum), .value(g_sat));
   ycc_clamp_u8 u_clamp_b (.sum(b_sum), .value(b_sat));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cb_s1  <= '0;
         cr_s1  <= '0;
         y_s1   <= '0;
         y_s2   <= '0;
         p_r_cr <= '0;
         p_g_cb <= '0;
         p_g_cr <= '0;
         p_b_cb <= '0;
         r_sum  <= '0;
         g_sum  <= '0;
         b_sum  <= '0;
         rgb    <= '0;
         hs_d   <= '0;
         vs_d   <= '0;
         de_d   <= '0;
      end else begin
         cb_s1  <= $signed({1'b0, pix.i_cb}) - C_OFFSET;
         cr_s1  <= $signed({1'b0, pix.i_cr}) - C_OFFSET;
         y_s1   <= $signed(18'(pix.i_y) << FRAC_BITS);

         y_s2   <= y_s1;
         p_r_cr <= 18'(cr_s1) * KR_CR;
         p_g_cb <= 18'(cb_s1) * KG_CB;
         p_g_cr <= 18'(cr_s1) * KG_CR;
         p_b_cb <= 18'(cb_s1) * KB_CB;

         r_sum  <= y_s2 + p_r_cr + RND;
         g_sum  <= y_s2 - p_g_cb - p_g_cr + RND;
         b_sum  <= y_s2 + p_b_cb + RND;

         // The stage-3 copy of data_en is the one that lands alongside this pixel.
         if (BLANK_ZERO && !de_d[PIPE_LAT-2])
            rgb <= '0;
         else
            rgb <= {r_sat, g_sat, b_sat};

         hs_d <= {hs_d[PIPE_LAT-2:0], pix.i_h_sync};
         vs_d <= {vs_d[PIPE_LAT-2:0], pix.i_v_sync};
         de_d <= {de_d[PIPE_LAT-2:0], pix.i_data_en};
      end
   end

   assign pix.o_rgb888  = rgb;
   assign pix.o_rgb565  = {rgb[23:19], rgb[15:10], rgb[7:3]};
   assign pix.o_h_sync  = hs_d[PIPE_LAT-1];
   assign pix.o_v_sync  = vs_d[PIPE_LAT-1];
   assign pix.o_data_en = de_d[PIPE_LAT-1];
endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// Bench for ycbcr_to_rgb565: directed vector table, timing/blanking burst, mid-stream reset
// and random pixels compared against an integer model of the conversion.
module tb_ycbcr_to_rgb565;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ycbcr_to_rgb565_if pix ();

   ycbcr_to_rgb565 #(.ROUND(1'b1), .BLANK_ZERO(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pix   (pix.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] rgb888;
      logic [15:0] rgb565;
      logic        hs;
      logic        vs;
      logic        de;
   } exp_t;

   typedef struct {
      logic [7:0]  y;
      logic [7:0]  cb;
      logic [7:0]  cr;
      logic [23:0] e888;
      logic [15:0] e565;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[6];

   function automatic int sat8(input int v);
      if (v < 0) return 0;
      if (v >= 65536) return 255;
      return v / 256;
   endfunction

   function automatic exp_t model(input int y, input int cb, input int cr,
                                  input logic hs, input logic vs, input logic de);
      exp_t e;
      int r, g, b;
      r = sat8(y * 256 + 359 * (cr - 128) + 128);
      g = sat8(y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128);
      b = sat8(y * 256 + 454 * (cb - 128) + 128);
      e.rgb888 = de ? 24'((r << 16) | (g << 8) | b) : 24'h0;
      e.rgb565 = {e.rgb888[23:19], e.rgb888[15:10], e.rgb888[7:3]};
      e.hs = hs;
      e.vs = vs;
      e.de = de;
      return e;
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_outputs(input exp_t e, input string tag);
      check({tag, " rgb888"}, pix.o_rgb888, e.rgb888);
      check({tag, " rgb565"}, 24'(pix.o_rgb565), 24'(e.rgb565));
      check({tag, " h_sync"}, 24'(pix.o_h_sync), 24'(e.hs));
      check({tag, " v_sync"}, 24'(pix.o_v_sync), 24'(e.vs));
      check({tag, " data_en"}, 24'(pix.o_data_en), 24'(e.de));
   endtask

   task automatic restart_pipe();
      exp_t z;
      z = '{rgb888: 24'h0, rgb565: 16'h0, hs: 1'b0, vs: 1'b0, de: 1'b0};
      exp_q.delete();
      repeat (3) exp_q.push_back(z);
   endtask

   // Drive one pixel, advance one clock, and check what leaves the pipe.
   task automatic step(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                       input logic hs, input logic vs, input logic de,
                       input bit use_tbl, input logic [23:0] t888, input logic [15:0] t565,
                       input string tag);
      exp_t e;
      pix.i_y = y;
      pix.i_cb = cb;
      pix.i_cr = cr;
      pix.i_h_sync = hs;
      pix.i_v_sync = vs;
      pix.i_data_en = de;
      e = model(int'(y), int'(cb), int'(cr), hs, vs, de);
      if (use_tbl) begin
         e.rgb888 = t888;
         e.rgb565 = t565;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_outputs(e, tag);
   endtask

   task automatic check_all_zero(input string tag);
      exp_t z;
      z = '{rgb888: 24'h0, rgb565: 16'h0, hs: 1'b0, vs: 1'b0, de: 1'b0};
      check_outputs(z, tag);
   endtask

   initial begin
      vecs[0] = '{y: 8'd128, cb: 8'd128, cr: 8'd128, e888: 24'h808080, e565: 16'h8410};
      vecs[1] = '{y: 8'd255, cb: 8'd128, cr: 8'd128, e888: 24'hFFFFFF, e565: 16'hFFFF};
      vecs[2] = '{y: 8'd0,   cb: 8'd128, cr: 8'd128, e888: 24'h000000, e565: 16'h0000};
      vecs[3] = '{y: 8'd76,  cb: 8'd85,  cr: 8'd255, e888: 24'hFE0000, e565: 16'hF800};
      vecs[4] = '{y: 8'd255, cb: 8'd128, cr: 8'd255, e888: 24'hFFA4FF, e565: 16'hFD3F};
      vecs[5] = '{y: 8'd0,   cb: 8'd128, cr: 8'd0,   e888: 24'h005C00, e565: 16'h02E0};

      pix.i_y = 8'hAA;
      pix.i_cb = 8'h11;
      pix.i_cr = 8'hEE;
      pix.i_h_sync = 1'b1;
      pix.i_v_sync = 1'b1;
      pix.i_data_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      restart_pipe();

      // Directed vectors back to back, then flush with blanked pixels.
      for (int i = 0; i < 6; i++)
         step(vecs[i].y, vecs[i].cb, vecs[i].cr, 1'b0, 1'b0, 1'b1,
              1'b1, vecs[i].e888, vecs[i].e565, $sformatf("vec%0d", i));
      for (int i = 0; i < 4; i++)
         step(8'd200, 8'd60, 8'd190, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, "flush");

      // Three-pixel burst with a one-clock h_sync pulse on its first pixel.
      for (int i = 0; i < 9; i++)
         step(8'd180, 8'd90, 8'd170, (i == 1), (i >= 1 && i <= 6), (i >= 1 && i <= 3),
              1'b0, 24'h0, 16'h0, $sformatf("burst%0d", i));

      // Reset asserted between clock edges in the middle of an active run.
      for (int i = 0; i < 5; i++)
         step(8'(40 * i + 20), 8'd100, 8'd150, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 16'h0, "pre_rst");
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_async");
      @(posedge clk);
      #1 check_all_zero("rst_held");
      #2 rst_n = 1'b1;
      restart_pipe();
      for (int i = 0; i < 8; i++)
         step(8'(30 * i + 10), 8'd140, 8'd110, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 16'h0,
              $sformatf("post_rst%0d", i));

      // Random pixels and timing.
      for (int i = 0; i < 400; i++)
         step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              1'b0, 24'h0, 16'h0, "rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
